// File: rtl/mio_bus_ctrl_pkg.sv
// Shared definitions for the memory/IO bus controller.
//   - Address-map bases, masks and timer register offsets.
//   - Bus FSM state encoding.
//   - Decode target encoding and the address decode helper.
package mio_bus_ctrl_pkg;

    localparam logic [31:0] RAM_BASE    = 32'h0000_0000;
    localparam logic [31:0] GPIO_BASE   = 32'hE000_0000;
    localparam logic [31:0] TIMER_BASE  = 32'hF000_0000;
    localparam logic [31:0] TMR_CNT_OFS = 32'h0000_0000;
    localparam logic [31:0] TMR_CTL_OFS = 32'h0000_0004;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RAM_RD = 2'd1,
        ST_RAM_WR = 2'd2,
        ST_ACK    = 2'd3
    } state_t;

    typedef enum logic [2:0] {
        TGT_RAM  = 3'd0,
        TGT_GPIO = 3'd1,
        TGT_TCNT = 3'd2,
        TGT_TCTL = 3'd3,
        TGT_NONE = 3'd4
    } target_t;

    // Mask selecting the address bits above the RAM window (4 * 2^aw bytes).
    function automatic logic [31:0] ram_win_mask(input int aw);
        return 32'hFFFF_FFFF << (aw + 2);
    endfunction

    // Peripheral registers are matched on the full address; any other
    // address outside the RAM window is unmapped.
    function automatic target_t decode(input logic [31:0] addr, input int aw);
        target_t t;
        if ((addr & ram_win_mask(aw)) == RAM_BASE)
            t = TGT_RAM;
        else if (addr == GPIO_BASE)
            t = TGT_GPIO;
        else if (addr == (TIMER_BASE | TMR_CNT_OFS))
            t = TGT_TCNT;
        else if (addr == (TIMER_BASE | TMR_CTL_OFS))
            t = TGT_TCTL;
        else
            t = TGT_NONE;
        return t;
    endfunction

endpackage

// File: rtl/mio_bus_ctrl_timer.sv
// mio_timer: 32-bit down-counting timer with a sticky expiry flag.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   cnt_we_i/_wdata_i   load the count (wins over a same-cycle decrement)
//   ctl_we_i/en_wdata_i write the enable bit
//   irq_clr_i           clear the sticky flag (a same-cycle set wins)
//   count_o, enable_o, irq_o  current timer state
module mio_timer
    import mio_bus_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cnt_we_i,
    input  logic [31:0] cnt_wdata_i,
    input  logic        ctl_we_i,
    input  logic        en_wdata_i,
    input  logic        irq_clr_i,
    output logic [31:0] count_o,
    output logic        enable_o,
    output logic        irq_o
);

    logic [31:0] count_q, count_d;
    logic        enable_q, enable_d;
    logic        irq_q, irq_d;

    always_comb begin
        count_d  = count_q;
        enable_d = enable_q;
        irq_d    = irq_q;
        if (ctl_we_i)
            enable_d = en_wdata_i;
        if (irq_clr_i)
            irq_d = 1'b0;
        if (cnt_we_i) begin
            count_d = cnt_wdata_i;
        end else if (enable_q) begin
            // Wraps naturally from 0 to 0xFFFF_FFFF; only 1->0 flags expiry.
            count_d = count_q - 32'd1;
            if (count_q == 32'd1)
                irq_d = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q  <= 32'd0;
            enable_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            count_q  <= count_d;
            enable_q <= enable_d;
            irq_q    <= irq_d;
        end
    end

    assign count_o  = count_q;
    assign enable_o = enable_q;
    assign irq_o    = irq_q;

endmodule

// File: rtl/mio_bus_ctrl.sv
// mio_bus_ctrl: data-side bus controller between the CPU core and the
// RAM / GPIO / timer targets. One transaction at a time; MIO_ready pulses
// for one cycle with Data_in valid when the access completes.
// Ports:
//   clk, reset                     clock, asynchronous active-high reset
//   CPU_MIO, mem_w, Addr_out,
//   Data_out                       CPU request
//   Data_in, MIO_ready             completion data and pulse to the CPU
//   ram_en, ram_we, ram_addr,
//   ram_din, ram_dout              synchronous RAM port
//   sw_in, led_out                 GPIO switches and LED register
//   timer_irq                      sticky timer-expired flag
//   bus_err                        pulse on an unmapped access
module mio_bus_ctrl
    import mio_bus_ctrl_pkg::*;
#(
    parameter int          RAM_LAT  = 2,
    parameter int          RAM_AW   = 10,
    parameter logic [31:0] GPIO_RST = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              CPU_MIO,
    input  logic              mem_w,
    input  logic [31:0]       Addr_out,
    input  logic [31:0]       Data_out,
    output logic [31:0]       Data_in,
    output logic              MIO_ready,
    output logic              ram_en,
    output logic              ram_we,
    output logic [RAM_AW-1:0] ram_addr,
    output logic [31:0]       ram_din,
    input  logic [31:0]       ram_dout,
    input  logic [15:0]       sw_in,
    output logic [31:0]       led_out,
    output logic              timer_irq,
    output logic              bus_err
);

    localparam logic [2:0] LAT_LAST = 3'(RAM_LAT);

    state_t            state_q;
    logic [RAM_AW-1:0] addr_q;
    logic [31:0]       wdata_q;
    logic [2:0]        lat_q;
    logic              mio_ready_q, ram_en_q, ram_we_q, bus_err_q;
    logic [31:0]       data_in_q, led_q;

    target_t     req_tgt;
    logic        accept;
    logic [31:0] periph_rdata;
    logic [31:0] tmr_count;
    logic        tmr_en, tmr_irq;

    assign req_tgt = decode(Addr_out, RAM_AW);
    assign accept  = (state_q == ST_IDLE) && CPU_MIO;

    // Peripheral side effects happen on the accept edge itself.
    mio_timer u_timer (
        .clk         (clk),
        .reset       (reset),
        .cnt_we_i    (accept && mem_w && (req_tgt == TGT_TCNT)),
        .cnt_wdata_i (Data_out),
        .ctl_we_i    (accept && mem_w && (req_tgt == TGT_TCTL)),
        .en_wdata_i  (Data_out[0]),
        .irq_clr_i   (accept && !mem_w && (req_tgt == TGT_TCTL)),
        .count_o     (tmr_count),
        .enable_o    (tmr_en),
        .irq_o       (tmr_irq)
    );

    always_comb begin
        periph_rdata = 32'd0;
        case (req_tgt)
            TGT_GPIO: periph_rdata = {16'h0000, sw_in};
            TGT_TCNT: periph_rdata = tmr_count;
            TGT_TCTL: periph_rdata = {30'd0, tmr_irq, tmr_en};
            default:  periph_rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            wdata_q     <= 32'd0;
            lat_q       <= 3'd0;
            mio_ready_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            data_in_q   <= 32'd0;
            led_q       <= GPIO_RST;
        end else begin
            // Pulse outputs default low; Data_in is only non-zero during ACK.
            mio_ready_q <= 1'b0;
            ram_en_q    <= 1'b0;
            ram_we_q    <= 1'b0;
            bus_err_q   <= 1'b0;
            data_in_q   <= 32'd0;
            case (state_q)
                ST_IDLE: begin
                    if (CPU_MIO) begin
                        addr_q  <= Addr_out[RAM_AW+1:2];
                        wdata_q <= Data_out;
                        if (req_tgt == TGT_RAM) begin
                            // RAM strobes are high for the first cycle only.
                            ram_en_q <= 1'b1;
                            ram_we_q <= mem_w;
                            lat_q    <= 3'd0;
                            state_q  <= mem_w ? ST_RAM_WR : ST_RAM_RD;
                        end else begin
                            mio_ready_q <= 1'b1;
                            bus_err_q   <= (req_tgt == TGT_NONE);
                            if (!mem_w)
                                data_in_q <= periph_rdata;
                            if (mem_w && (req_tgt == TGT_GPIO))
                                led_q <= Data_out;
                            state_q <= ST_ACK;
                        end
                    end
                end
                ST_RAM_WR: begin
                    mio_ready_q <= 1'b1;
                    state_q     <= ST_ACK;
                end
                ST_RAM_RD: begin
                    // lat_q reaches RAM_LAT on the edge where ram_dout is valid.
                    if (lat_q == LAT_LAST) begin
                        data_in_q   <= ram_dout;
                        mio_ready_q <= 1'b1;
                        state_q     <= ST_ACK;
                    end else begin
                        lat_q <= lat_q + 3'd1;
                    end
                end
                ST_ACK: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign Data_in   = data_in_q;
    assign MIO_ready = mio_ready_q;
    assign ram_en    = ram_en_q;
    assign ram_we    = ram_we_q;
    assign ram_addr  = addr_q;
    assign ram_din   = wdata_q;
    assign bus_err   = bus_err_q;
    assign led_out   = led_q;
    assign timer_irq = tmr_irq;

endmodule

// File: doc/mio_bus_ctrl.md
Name: mio_bus_ctrl

Overview:
- Memory/IO bus controller directly downstream of the CPU core.
- Consumes the core's data-side request (Addr_out, Data_out, mem_w, CPU_MIO) and decodes it to one of three targets:
  - synchronous data RAM with multi-cycle read latency;
  - GPIO (LED/switch) register;
  - 32-bit timer.
- Returns read data on Data_in and a one-cycle MIO_ready completion pulse; the core stalls on it.

Parameters:
- RAM_LAT, 2: cycles from ram_en assertion to valid ram_dout; legal range 1..7.
- RAM_AW, 10: RAM word-address width; RAM window is 4*2^RAM_AW bytes.
- GPIO_RST, 32'h0000_0000: reset value of the LED register.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- CPU_MIO  in  1  CPU bus request.
- mem_w  in  1  1 = write, 0 = read; valid with CPU_MIO.
- Addr_out  in  32  byte address from the CPU.
- Data_out  in  32  CPU write data.
- Data_in  out  32  read data to the CPU; valid while MIO_ready=1.
- MIO_ready  out  1  transaction-complete pulse.
- ram_en  out  1  RAM access enable.
- ram_we  out  1  RAM write enable.
- ram_addr  out  RAM_AW  RAM word address, Addr_out[RAM_AW+1:2].
- ram_din  out  32  RAM write data.
- ram_dout  in  32  RAM read data.
- sw_in  in  16  switch inputs.
- led_out  out  32  LED register.
- timer_irq  out  1  sticky timer-expired flag.
- bus_err  out  1  one-cycle pulse on an access to an unmapped address.

Behaviour:
- Address map:
  - 0x0000_0000 + 4*2^RAM_AW window: RAM.
  - 0xE000_0000: GPIO. Write sets led_out; read returns {16'h0, sw_in}.
  - 0xF000_0000: timer count. Write loads count; read returns count.
  - 0xF000_0004: timer control. bit0 = enable. Read returns {30'h0, timer_irq, enable} and clears timer_irq.
  - Anything else: unmapped.
- FSM states: IDLE, RAM_RD, RAM_WR, ACK.
- IDLE:
  - CPU_MIO=1 is accepted on the clock edge. Addr_out, Data_out and mem_w are captured into registers; the CPU inputs are ignored afterwards until the next IDLE.
  - RAM read goes to RAM_RD; RAM write goes to RAM_WR; GPIO, timer and unmapped accesses go to ACK.
- RAM_RD:
  - ram_en=1 for the first cycle only.
  - A latency counter counts RAM_LAT cycles. Then ram_dout is latched into the read-data register and the FSM goes to ACK.
- RAM_WR: ram_en=ram_we=1 for exactly one cycle, then ACK.
- ACK:
  - MIO_ready=1 for exactly one cycle and Data_in is valid; next state IDLE.
  - Writes and unmapped reads return Data_in=0.
  - Unmapped accesses also pulse bus_err for that same cycle and have no side effects.
- Latency, accept edge to MIO_ready high:
  - peripheral: 1 cycle;
  - RAM write: 2 cycles;
  - RAM read: RAM_LAT+2 cycles.
- Back-to-back transactions: a request held through ACK is re-accepted at the next IDLE edge, giving a minimum of 1 idle cycle between transactions.
- Peripheral writes take effect on the accept edge; peripheral reads are sampled on the accept edge.
- Timer:
  - When enable=1, count decrements every cycle.
  - The transition 1→0 sets timer_irq, and count wraps to 0xFFFF_FFFF and continues.
  - A CPU load on the same cycle as a decrement wins.
  - If a control read that clears timer_irq coincides with a set, timer_irq remains 1 (set wins).
- Reset (asynchronous, any state, including mid-transaction):
  - State → IDLE.
  - MIO_ready, ram_en, ram_we, bus_err, timer_irq, Data_in, count, enable → 0.
  - led_out → GPIO_RST.
  - An in-flight transaction is abandoned with no ready pulse.
- Outputs are registered except ram_addr and ram_din, which are driven from the captured registers.

Decomposition:
- Shared package holds:
  - address-map base and mask constants;
  - FSM state encoding;
  - register offsets 0x0 and 0x4.
- One sub-module, mio_timer: count, enable and irq logic, with the load and clear ports driven by the bus FSM.

Test Plan:
- Reset, then RAM write 0x0000_0010 ← 0xDEADBEEF → ram_we=1 with ram_addr=4 one cycle after accept; MIO_ready exactly 2 cycles after accept.
- Read back 0x0000_0010 with RAM_LAT=2 (model returns 0xDEADBEEF) → ram_en for 1 cycle; MIO_ready plus Data_in=0xDEADBEEF 4 cycles after accept.
- Write 0xE000_0000 ← 0x0000_00A5 → led_out=0xA5 after the accept edge; read with sw_in=0x1234 → Data_in=0x0000_1234, MIO_ready 1 cycle after accept.
- Timer load 3, enable=1 → timer_irq=1 3 cycles after enable takes effect; read 0xF000_0004 → Data_in=0x3 and timer_irq cleared.
- Access 0x8000_0000 → bus_err and MIO_ready pulse together with Data_in=0; led_out, count and RAM unchanged.
- Assert reset during RAM_RD → no MIO_ready; all outputs at reset values; a new request after release completes normally.
